// File: rtl/player_pkg.sv
// Shared keycodes, direction/state enums and key decode for the player mover.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. SPACE decode exists only when PLAYER_SPRINT_EN is defined.
package player_pkg;

    localparam logic [7:0] KEY_UP    = 8'd82;
    localparam logic [7:0] KEY_DOWN  = 8'd81;
    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_Z     = 8'd29;
    localparam logic [7:0] KEY_SPACE = 8'd44;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WALK     = 2'd1,
        ST_ATTACK   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic z;
`ifdef PLAYER_SPRINT_EN
        logic space;
`endif
    } keys_t;

    // Decode one keycode slot; callers OR the results of all slots together.
    function automatic keys_t decode_slot(input logic [7:0] code);
        keys_t k;
        k.up    = (code == KEY_UP);
        k.down  = (code == KEY_DOWN);
        k.left  = (code == KEY_LEFT);
        k.right = (code == KEY_RIGHT);
        k.z     = (code == KEY_Z);
`ifdef PLAYER_SPRINT_EN
        k.space = (code == KEY_SPACE);
`endif
        return k;
    endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Render-side pixel query bus: renderer drives the pixel, player answers hit/address.
// Latency: combinational through the player.
// Backpressure: none, the answer is valid for whatever pixel is presented.
interface player_motion_ctrl_if #(
    parameter int COORD_W = 9,
    parameter int ADDR_W  = 13
) ();
    logic [COORD_W-1:0] PixelX;
    logic [COORD_W-1:0] PixelY;
    logic               is_obj;
    logic [ADDR_W-1:0]  Obj_address;

    modport master (output PixelX, PixelY, input is_obj, Obj_address);
    modport slave  (input PixelX, PixelY, output is_obj, Obj_address);
endinterface

// File: rtl/player_anim_ctr.sv
// Walk animation: tick divider plus walk-frame counter cycling 1..FRAMES-2.
// Latency: frame index updates on the same tick edge that reports motion.
// Backpressure: none; holds whenever tick is low.
module player_anim_ctr #(
    parameter int FRAMES = 4,
    parameter int DIV_W  = 1,
    parameter int FR_W   = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             tick,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIV_W-1:0] div,
    output logic [FR_W-1:0]  frame,
    output logic             wrap
);
    localparam logic [FR_W-1:0] LAST_WALK = FR_W'(FRAMES - 2);

    logic [DIV_W-1:0] div_cnt;
    logic             div_done;

    assign div_done = ({1'b0, div_cnt} + 1'b1) >= {1'b0, div};

    // Divide ticks while moving; wrap back to the first walk frame after the last.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt <= '0;
            frame   <= '0;
            wrap    <= 1'b0;
        end else if (tick) begin
            wrap <= 1'b0;
            if (clear) begin
                div_cnt <= '0;
                frame   <= '0;
            end else if (advance) begin
                if (div_done) begin
                    div_cnt <= '0;
                    if (frame >= LAST_WALK) begin
                        frame <= FR_W'(1);
                        wrap  <= (frame != '0);
                    end else begin
                        frame <= frame + 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/player_motion_ctrl.sv
// Player sprite mover: key decode, clamped per-tick motion, attack FSM, sprite hit/address.
// Latency: state updates one Clk after a frame_tick; pixel hit/address are combinational.
// Backpressure: Freeze holds all state; optional sprint under macro PLAYER_SPRINT_EN.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int COORD_W   = 9,
    parameter int KEY_SLOTS = 2,
    parameter int SPR_W     = 18,
    parameter int SPR_H     = 20,
    parameter int X_CENTER  = 160,
    parameter int Y_CENTER  = 120,
    parameter int X_MIN     = 1,
    parameter int X_MAX     = 319,
    parameter int Y_MIN     = 52,
    parameter int Y_MAX     = 205,
    parameter int STEP      = 3,
    parameter int DIAG      = 0,
    parameter int FRAMES    = 4,
    parameter int ANIM_DIV  = 1,
    parameter int ATK_TICKS = 6,
    parameter int CD_TICKS  = 10,
    parameter int ADDR_W    = 13
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic                   Freeze,
    input  logic [8*KEY_SLOTS-1:0] keycode,
    player_motion_ctrl_if.slave    pix,
    output logic [COORD_W-1:0]     Obj_X_Pos,
    output logic [COORD_W-1:0]     Obj_Y_Pos,
    output logic [1:0]             Obj_Direction,
    output logic                   Attack_On,
    output logic                   Moving
);
    localparam int CW1     = COORD_W + 1;
    localparam int CNT_MAX = (ATK_TICKS > CD_TICKS) ? ATK_TICKS : CD_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FR_W    = (FRAMES > 2) ? $clog2(FRAMES) : 1;
    localparam int DIV_W   = $clog2(ANIM_DIV + 1);

    localparam logic [CW1-1:0]     X_LO  = CW1'(X_MIN);
    localparam logic [CW1-1:0]     X_HI  = CW1'(X_MAX - SPR_W);
    localparam logic [CW1-1:0]     Y_LO  = CW1'(Y_MIN);
    localparam logic [CW1-1:0]     Y_HI  = CW1'(Y_MAX - SPR_H);
    localparam logic [COORD_W-1:0] X_RST = COORD_W'(X_CENTER - SPR_W / 2);
    localparam logic [COORD_W-1:0] Y_RST = COORD_W'(Y_CENTER - SPR_H / 2);

    // Step one axis at COORD_W+1 bits so a move past 0 clamps instead of wrapping.
    function automatic logic [COORD_W-1:0] move_axis(
        input logic [COORD_W-1:0] pos, input logic inc, input logic dec,
        input logic [CW1-1:0] step, input logic [CW1-1:0] lo, input logic [CW1-1:0] hi);
        logic [CW1-1:0] p, r;
        p = {1'b0, pos};
        r = p;
        if (inc)      r = (p + step > hi) ? hi : p + step;
        else if (dec) r = (p < lo + step) ? lo : p - step;
        return r[COORD_W-1:0];
    endfunction

    state_e             state_q;
    dir_e               dir_q, dir_new;
    logic [CNT_W-1:0]   cnt_q;
    keys_t              keys;
    logic               mv_key, move_ok, has_dir, moved, tick_en, to_idle;
    logic               atk_done, cd_done;
    logic               x_inc, x_dec, y_inc, y_dec;
    logic [CW1-1:0]     step;
    logic [DIV_W-1:0]   anim_div;
    logic [COORD_W-1:0] x_nxt, y_nxt, dx, dy;
    logic [FR_W-1:0]    walk_frame, frame_sel;
    logic               anim_wrap;

    // Merge all keycode slots into one pressed-key set.
    always_comb begin
        keys = '0;
        for (int i = 0; i < KEY_SLOTS; i++) keys = keys | decode_slot(keycode[8*i +: 8]);
    end

    assign mv_key   = keys.up | keys.down | keys.left | keys.right;
    assign tick_en  = frame_tick & ~Freeze;
    assign atk_done = (cnt_q == CNT_W'(ATK_TICKS - 1));
    assign cd_done  = (cnt_q == CNT_W'(CD_TICKS - 1));
    // Attack request in IDLE/WALK pre-empts motion; COOLDOWN moves and ignores Z.
    assign move_ok  = (state_q == ST_COOLDOWN) ||
                      ((state_q == ST_IDLE || state_q == ST_WALK) && !keys.z);
    assign to_idle  = (state_q == ST_WALK && !keys.z && !mv_key) ||
                      (state_q == ST_COOLDOWN && cd_done && !mv_key);

    // Resolve axis requests: single axis by priority, or independent axes with cancel.
    always_comb begin
        x_inc = 1'b0; x_dec = 1'b0; y_inc = 1'b0; y_dec = 1'b0;
        if (DIAG != 0) begin
            x_inc = keys.right & ~keys.left;
            x_dec = keys.left  & ~keys.right;
            y_inc = keys.down  & ~keys.up;
            y_dec = keys.up    & ~keys.down;
        end else if (keys.right) x_inc = 1'b1;
        else if (keys.left)      x_dec = 1'b1;
        else if (keys.down)      y_inc = 1'b1;
        else if (keys.up)        y_dec = 1'b1;
    end

    assign has_dir = x_inc | x_dec | y_inc | y_dec;
    assign dir_new = x_inc ? DIR_RIGHT : x_dec ? DIR_LEFT : y_inc ? DIR_DOWN : DIR_UP;

    // Effective step and animation divider, doubled/halved while sprinting.
`ifdef PLAYER_SPRINT_EN
    localparam int SPRINT_DIV = (ANIM_DIV / 2 > 1) ? ANIM_DIV / 2 : 1;
    logic sprint;
    assign sprint   = keys.space && (state_q == ST_WALK || state_q == ST_COOLDOWN);
    assign step     = sprint ? CW1'(2 * STEP) : CW1'(STEP);
    assign anim_div = sprint ? DIV_W'(SPRINT_DIV) : DIV_W'(ANIM_DIV);
`else
    assign step     = CW1'(STEP);
    assign anim_div = DIV_W'(ANIM_DIV);
`endif

    assign x_nxt = move_axis(Obj_X_Pos, x_inc & move_ok, x_dec & move_ok, step, X_LO, X_HI);
    assign y_nxt = move_axis(Obj_Y_Pos, y_inc & move_ok, y_dec & move_ok, step, Y_LO, Y_HI);
    assign moved = (x_nxt != Obj_X_Pos) || (y_nxt != Obj_Y_Pos);

    // FSM, attack/cooldown counter, position, facing and flags; all advance on ticks only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dir_q     <= DIR_DOWN;
            Obj_X_Pos <= X_RST;
            Obj_Y_Pos <= Y_RST;
            Attack_On <= 1'b0;
            Moving    <= 1'b0;
        end else if (tick_en) begin
            Obj_X_Pos <= x_nxt;
            Obj_Y_Pos <= y_nxt;
            Moving    <= moved;
            if (move_ok && has_dir) dir_q <= dir_new;
            case (state_q)
                ST_IDLE, ST_WALK: begin
                    cnt_q     <= '0;
                    Attack_On <= keys.z;
                    if (keys.z)      state_q <= ST_ATTACK;
                    else if (mv_key) state_q <= ST_WALK;
                    else             state_q <= ST_IDLE;
                end
                ST_ATTACK: begin
                    cnt_q     <= atk_done ? '0 : cnt_q + 1'b1;
                    Attack_On <= !atk_done;
                    if (atk_done) state_q <= ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    cnt_q     <= cd_done ? '0 : cnt_q + 1'b1;
                    Attack_On <= 1'b0;
                    if (cd_done) state_q <= mv_key ? ST_WALK : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    player_anim_ctr #(.FRAMES(FRAMES), .DIV_W(DIV_W), .FR_W(FR_W)) u_anim (
        .Clk     (Clk),
        .Reset   (Reset),
        .tick    (tick_en),
        .clear   (to_idle),
        .advance (moved),
        .div     (anim_div),
        .frame   (walk_frame),
        .wrap    (anim_wrap)
    );

    assign Obj_Direction = dir_q;
    assign frame_sel     = Attack_On ? FR_W'(FRAMES - 1) : (Moving ? walk_frame : '0);

    // Sprite box hit test and ROM address for the pixel being rendered.
    assign pix.is_obj = (pix.PixelX >= Obj_X_Pos) &&
                        ({1'b0, pix.PixelX} < {1'b0, Obj_X_Pos} + CW1'(SPR_W)) &&
                        (pix.PixelY >= Obj_Y_Pos) &&
                        ({1'b0, pix.PixelY} < {1'b0, Obj_Y_Pos} + CW1'(SPR_H));
    assign dx = pix.PixelX - Obj_X_Pos;
    assign dy = pix.PixelY - Obj_Y_Pos;
    assign pix.Obj_address = pix.is_obj ?
        ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(SPR_W) +
        ADDR_W'(SPR_W * SPR_H) * (ADDR_W'(FRAMES) * ADDR_W'(dir_q) + ADDR_W'(frame_sel)) : '0;
endmodule
